// File: rtl/decoded_bit_register.sv
// decoded_bit_register
// Output-side frame buffer for the semi-parallel SC decoder. Captures the
// hard-decision bits u_hat written one per cycle during a frame, forces
// frozen positions to zero, optionally compacts the K information bits, and
// presents the frame on a valid/ready handshake.
//
// Build option: define DECODED_INFO_EXTRACT_EN to build the EXTRACT state,
// its index/info counters and the info register. Without it, COLLECT goes
// straight to HOLD on decoder_done and info_bits is tied to zero.
module decoded_bit_register #(
  parameter int                  n           = 3,
  parameter int                  K           = 4,
  parameter logic [(2**n)-1:0]   FROZEN_MASK = 8'b0001_0111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                decoder_busy,
  input  logic                decoder_done,
  input  logic                u_hat_wr_en,
  input  logic [n-1:0]        u_hat_address,
  input  logic                u_hat,
  input  logic                dout_ready,
  output logic [(2**n)-1:0]   dout,
  output logic [K-1:0]        info_bits,
  output logic                dout_valid,
  output logic                output_register_ready,
  output logic                overrun
);

  localparam int N = 2**n;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
`ifdef DECODED_INFO_EXTRACT_EN
  localparam logic [1:0] S_EXTRACT = 2'd2;
`endif
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]   state;
  logic [N-1:0] u_reg;
  logic         busy_d;
  logic         busy_rise;
  logic         frame_start;
  logic         extract_or_hold;

`ifdef DECODED_INFO_EXTRACT_EN
  localparam int               KPW    = $clog2(K + 1);
  localparam logic [n:0]       I_LAST = (n+1)'(N - 1);
  localparam logic [KPW-1:0]   K_MAX  = KPW'(K);

  logic [n:0]     i_cnt;
  logic [n-1:0]   i_idx;
  logic [KPW-1:0] k_cnt;
  logic [K-1:0]   info_reg;

  // Info pointer advances by one but never past K, so surplus non-frozen
  // positions are skipped rather than wrapping onto earlier info bits.
  function automatic logic [KPW-1:0] k_sat_inc(input logic [KPW-1:0] k);
    if (k >= K_MAX) return K_MAX;
    return k + 1'b1;
  endfunction

  assign i_idx = i_cnt[n-1:0];
`endif

  // A new frame begins on the edge where IDLE samples decoder_busy high.
  assign frame_start = (state == S_IDLE) && decoder_busy;
  assign busy_rise   = decoder_busy && !busy_d;

`ifdef DECODED_INFO_EXTRACT_EN
  assign extract_or_hold = (state == S_EXTRACT) || (state == S_HOLD);
`else
  assign extract_or_hold = (state == S_HOLD);
`endif

  // Frame state machine and extraction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
`ifdef DECODED_INFO_EXTRACT_EN
      i_cnt <= '0;
      k_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (decoder_busy) state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (decoder_done) begin
`ifdef DECODED_INFO_EXTRACT_EN
            state <= S_EXTRACT;
            i_cnt <= '0;
            k_cnt <= '0;
`else
            state <= S_HOLD;
`endif
          end
        end
`ifdef DECODED_INFO_EXTRACT_EN
        S_EXTRACT: begin
          if (!FROZEN_MASK[i_idx]) k_cnt <= k_sat_inc(k_cnt);
          if (i_cnt == I_LAST) state <= S_HOLD;
          else                 i_cnt <= i_cnt + 1'b1;
        end
`endif
        S_HOLD: begin
          if (dout_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decided-bit register: cleared at frame start, written only in COLLECT,
  // frozen positions always stored as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_reg <= '0;
    end else if (frame_start) begin
      u_reg <= '0;
    end else if ((state == S_COLLECT) && u_hat_wr_en) begin
      u_reg[u_hat_address] <= u_hat & ~FROZEN_MASK[u_hat_address];
    end
  end

`ifdef DECODED_INFO_EXTRACT_EN
  // Info register: compacts non-frozen bits in index order, lowest first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      info_reg <= '0;
    end else if (frame_start) begin
      info_reg <= '0;
    end else if ((state == S_EXTRACT) && !FROZEN_MASK[i_idx] && (k_cnt < K_MAX)) begin
      for (int j = 0; j < K; j++) begin
        if (k_cnt == KPW'(j)) info_reg[j] <= u_reg[i_idx];
      end
    end
  end

  assign info_bits = info_reg;
`else
  assign info_bits = '0;
`endif

  // Sticky overrun flag: a frame start (busy rising) while still draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_d  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      busy_d <= decoder_busy;
      if (busy_rise && extract_or_hold) overrun <= 1'b1;
    end
  end

  assign dout                  = u_reg;
  assign dout_valid            = (state == S_HOLD);
  assign output_register_ready = (state == S_IDLE);

endmodule

// File: tb/tb_decoded_bit_register.sv
// Directed testbench for decoded_bit_register (n=3, K=4, mask 8'b0001_0111).
// Expectations adapt to whether DECODED_INFO_EXTRACT_EN is defined.
module tb_decoded_bit_register;

  localparam int n = 3;
  localparam int K = 4;
  localparam int N = 8;
  localparam logic [7:0] MASK = 8'b0001_0111;

`ifdef DECODED_INFO_EXTRACT_EN
  localparam int EXP_LAT = N + 1;
  localparam bit EXT     = 1'b1;
`else
  localparam int EXP_LAT = 1;
  localparam bit EXT     = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         decoder_busy;
  logic         decoder_done;
  logic         u_hat_wr_en;
  logic [n-1:0] u_hat_address;
  logic         u_hat;
  logic         dout_ready;
  logic [N-1:0] dout;
  logic [K-1:0] info_bits;
  logic         dout_valid;
  logic         output_register_ready;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  decoded_bit_register #(.n(n), .K(K), .FROZEN_MASK(MASK)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .decoder_busy          (decoder_busy),
    .decoder_done          (decoder_done),
    .u_hat_wr_en           (u_hat_wr_en),
    .u_hat_address         (u_hat_address),
    .u_hat                 (u_hat),
    .dout_ready            (dout_ready),
    .dout                  (dout),
    .info_bits             (info_bits),
    .dout_valid            (dout_valid),
    .output_register_ready (output_register_ready),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [K-1:0] exp_info(input logic [K-1:0] v);
    return EXT ? v : '0;
  endfunction

  // Stimulus helpers; every task starts and ends just after a falling edge.
  task automatic start_frame();
    decoder_busy = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_bit(input logic [n-1:0] a, input logic v);
    u_hat_wr_en = 1'b1; u_hat_address = a; u_hat = v;
    @(negedge clk);
    u_hat_wr_en = 1'b0;
  endtask

  task automatic pulse_done(output int cyc);
    decoder_done = 1'b1; decoder_busy = 1'b0;
    @(negedge clk);
    decoder_done = 1'b0; u_hat_wr_en = 1'b0;
    cyc = 1;
    while (!dout_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Nominal frame: frozen positions written as 1, u3=1 u5=0 u6=1 u7=1.
  task automatic load_nominal();
    start_frame();
    write_bit(3'd0, 1'b1); write_bit(3'd1, 1'b1);
    write_bit(3'd2, 1'b1); write_bit(3'd4, 1'b1);
    write_bit(3'd3, 1'b1); write_bit(3'd5, 1'b0);
    write_bit(3'd6, 1'b1); write_bit(3'd7, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; decoder_busy = 1'b0; decoder_done = 1'b0; u_hat_wr_en = 1'b0;
    u_hat_address = '0; u_hat = 1'b0; dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (info_bits !== 4'h0) begin bad++; $display("FAIL reset_info got=%h exp=0", info_bits); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if (output_register_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", output_register_ready); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_nominal();
    int cyc;
    start_frame();
    total++; if (output_register_ready !== 1'b0) begin bad++; $display("FAIL nom_ready_drop got=%b exp=0", output_register_ready); end
    write_bit(3'd0, 1'b1); write_bit(3'd1, 1'b1);
    write_bit(3'd2, 1'b1); write_bit(3'd4, 1'b1);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL nom_frozen got=%h exp=00", dout); end
    write_bit(3'd3, 1'b1);
    total++; if (dout !== 8'h08) begin bad++; $display("FAIL nom_wr_latency got=%h exp=08", dout); end
    write_bit(3'd5, 1'b1);
    total++; if (dout !== 8'h28) begin bad++; $display("FAIL nom_wr5 got=%h exp=28", dout); end
    write_bit(3'd5, 1'b0);
    total++; if (dout !== 8'h08) begin bad++; $display("FAIL nom_overwrite got=%h exp=08", dout); end
    write_bit(3'd6, 1'b1);
    // last write shares the cycle with done
    u_hat_wr_en = 1'b1; u_hat_address = 3'd7; u_hat = 1'b1;
    pulse_done(cyc);
    total++; if (cyc !== EXP_LAT) begin bad++; $display("FAIL nom_latency got=%0d exp=%0d", cyc, EXP_LAT); end
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL nom_valid got=%b exp=1", dout_valid); end
    total++; if (dout !== 8'hC8) begin bad++; $display("FAIL nom_dout got=%h exp=c8", dout); end
    total++; if (info_bits !== exp_info(4'b1101)) begin bad++; $display("FAIL nom_info got=%b exp=%b", info_bits, exp_info(4'b1101)); end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL nom_valid_drop got=%b exp=0", dout_valid); end
    total++; if (output_register_ready !== 1'b1) begin bad++; $display("FAIL nom_idle got=%b exp=1", output_register_ready); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL nom_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_backpressure();
    int cyc;
    load_nominal();
    pulse_done(cyc);
    total++; if (cyc !== EXP_LAT) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", cyc, EXP_LAT); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (dout_valid !== 1'b1 || dout !== 8'hC8 || info_bits !== exp_info(4'b1101)) begin
        bad++; $display("FAIL bp_stable cyc=%0d got v=%b d=%h i=%b exp v=1 d=c8 i=%b", c, dout_valid, dout, info_bits, exp_info(4'b1101));
      end
    end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0 || output_register_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", dout_valid, output_register_ready);
    end
  endtask

  task automatic test_ignored();
    int cyc;
    write_bit(3'd3, 1'b1);
    write_bit(3'd5, 1'b1);
    total++; if (dout !== 8'hC8) begin bad++; $display("FAIL ign_idle_wr got=%h exp=c8", dout); end
    decoder_done = 1'b1;
    @(negedge clk);
    decoder_done = 1'b0;
    @(negedge clk);
    total++; if (dout_valid !== 1'b0 || output_register_ready !== 1'b1) begin
      bad++; $display("FAIL ign_idle_done got v=%b r=%b exp v=0 r=1", dout_valid, output_register_ready);
    end
    start_frame();
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL ign_clear got=%h exp=00", dout); end
    write_bit(3'd6, 1'b1);
    pulse_done(cyc);
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL ign_valid got=%b exp=1", dout_valid); end
    write_bit(3'd3, 1'b1);
    write_bit(3'd5, 1'b1);
    total++; if (dout !== 8'h40) begin bad++; $display("FAIL ign_hold_wr got=%h exp=40", dout); end
    total++; if (info_bits !== exp_info(4'b0100)) begin bad++; $display("FAIL ign_info got=%b exp=%b", info_bits, exp_info(4'b0100)); end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int cyc;
    load_nominal();
    decoder_done = 1'b1; decoder_busy = 1'b0;
    @(negedge clk);
    decoder_done = 1'b0; decoder_busy = 1'b1;
    @(negedge clk);
    decoder_busy = 1'b0;
    cyc = 2;
    while (!dout_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1 (timeout)", dout_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    total++; if (dout !== 8'hC8) begin bad++; $display("FAIL ovr_dout got=%h exp=c8", dout); end
    total++; if (info_bits !== exp_info(4'b1101)) begin bad++; $display("FAIL ovr_info got=%b exp=%b", info_bits, exp_info(4'b1101)); end
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (output_register_ready !== 1'b1) begin bad++; $display("FAIL ovr_idle got=%b exp=1", output_register_ready); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid_collect();
    start_frame();
    write_bit(3'd3, 1'b1); write_bit(3'd6, 1'b1); write_bit(3'd7, 1'b1);
    total++; if (dout !== 8'hC8) begin bad++; $display("FAIL rmc_pre got=%h exp=c8", dout); end
    rst_n = 1'b0; decoder_busy = 1'b0;
    #1;
    total++; if (dout !== 8'h00 || info_bits !== 4'h0) begin
      bad++; $display("FAIL rmc_data got d=%h i=%h exp d=00 i=0", dout, info_bits);
    end
    total++; if (dout_valid !== 1'b0 || output_register_ready !== 1'b1 || overrun !== 1'b0) begin
      bad++; $display("FAIL rmc_ctrl got v=%b r=%b o=%b exp v=0 r=1 o=0", dout_valid, output_register_ready, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (output_register_ready !== 1'b1 || dout !== 8'h00) begin
      bad++; $display("FAIL rmc_after got r=%b d=%h exp r=1 d=00", output_register_ready, dout);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    dout_ready = 1'b1;
    load_nominal();
    pulse_done(cyc);
    total++; if (cyc !== EXP_LAT) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=%0d", cyc, EXP_LAT); end
    @(negedge clk);
    total++; if (dout_valid !== 1'b0 || output_register_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_one_cycle got v=%b r=%b exp v=0 r=1", dout_valid, output_register_ready);
    end
    start_frame();
    write_bit(3'd5, 1'b1);
    pulse_done(cyc);
    total++; if (cyc !== EXP_LAT) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=%0d", cyc, EXP_LAT); end
    total++; if (dout !== 8'h20) begin bad++; $display("FAIL b2b_dout got=%h exp=20", dout); end
    total++; if (info_bits !== exp_info(4'b0010)) begin bad++; $display("FAIL b2b_info got=%b exp=%b", info_bits, exp_info(4'b0010)); end
    @(negedge clk);
    dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", dout_valid); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_ignored();
    test_overrun();
    test_reset_mid_collect();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoded_bit_register.md
# decoded_bit_register

Output-side frame buffer for the semi-parallel SC decoder. It captures hard-decision bits û written one per cycle by the decoder during a frame, forces frozen positions to zero, and compacts the K information bits. It then presents the frame on a valid/ready handshake. It is the counterpart of the channel LLR register: that block feeds the decoder, this one drains it.

## Interface
- n, 3, log2 of code length; N = 2**n.
- K, 4, number of information bits.
- FROZEN_MASK, 8'b0001_0111, N-bit vector; bit i = 1 means û index i is frozen.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- decoder_busy  in  1  decoder is decoding a frame.
- decoder_done  in  1  one-cycle pulse, last û written.
- u_hat_wr_en  in  1  write strobe for one decided bit.
- u_hat_address  in  n  natural-order index of the bit (0..N-1).
- u_hat  in  1  decided bit value.
- dout_ready  in  1  consumer accepts the frame.
- dout  out  N  full û vector, bit i = û_i.
- info_bits  out  K  compacted information bits, LSB = lowest non-frozen index.
- dout_valid  out  1  dout/info_bits valid.
- output_register_ready  out  1  block can accept a new frame (state IDLE).
- overrun  out  1  sticky; a frame start arrived while not IDLE.

## Operation
- States: IDLE, COLLECT, EXTRACT, HOLD.
- IDLE: output_register_ready=1. When decoder_busy=1, clear the û register and the info register, then go to COLLECT.
- COLLECT: on u_hat_wr_en, û[u_hat_address] <= u_hat & ~FROZEN_MASK[u_hat_address]. Frozen positions always store 0. Rewriting the same address overwrites it. On decoder_done, go to EXTRACT; a write in the same cycle as done is accepted.
- EXTRACT: index counter i runs 0..N-1, one per cycle; info pointer k starts at 0. If FROZEN_MASK[i]==0 and k<K: info[k] <= û[i], k++. After i=N-1, go to HOLD.
- HOLD: dout_valid=1, dout and info_bits stable. When dout_ready=1, go to IDLE the next cycle with dout_valid=0.
- Writes outside COLLECT are ignored.
- decoder_done outside COLLECT is ignored.
- overrun: set when decoder_busy rises (0 to 1) while the state is EXTRACT or HOLD. It clears only on reset. The current frame is unaffected. The new frame is lost unless decoder_busy is still high when IDLE is reached, in which case that frame is collected normally.
- Arithmetic: i is an n+1 bit counter. k is a ceil(log2(K+1)) bit pointer that saturates at K. Non-frozen positions beyond the K-th are not extracted.

## Timing
- Reset values: dout=0, info_bits=0, dout_valid=0, output_register_ready=1, overrun=0, state IDLE, counters 0.
- A reset mid-frame aborts immediately to IDLE with all registers cleared.
- IDLE to COLLECT: the edge on which decoder_busy=1 is sampled. output_register_ready drops the following cycle.
- Write latency: û is visible on dout (registered) the cycle after u_hat_wr_en.
- Done-to-valid latency: done sampled at edge t; EXTRACT occupies edges t+1..t+N; dout_valid is high from cycle t+N+1.
- Handshake: the transfer happens on the edge where dout_valid & dout_ready. If dout_ready is already high on entry to HOLD, dout_valid lasts exactly one cycle.
- Back-to-back frames: at minimum, N+2 cycles after done the block is IDLE again.

## Configuration
- DECODED_INFO_EXTRACT_EN defined: EXTRACT state, counters and the info register are built as described.
- Not defined: EXTRACT is removed and COLLECT goes straight to HOLD on decoder_done. dout_valid rises the cycle after done, and info_bits is tied to 0. FROZEN_MASK zero-forcing on writes is still applied.

## Test plan
- Nominal (n=3, K=4, mask 8'b0001_0111, macro defined): write û3=1, û5=0, û6=1, û7=1, frozen indices written as 1, done. Required: dout=8'b1100_1000, info_bits=4'b1101, dout_valid exactly 9 cycles after done.
- Backpressure: hold dout_ready=0 for 5 cycles in HOLD. Required: dout_valid and data stable; IDLE one cycle after dout_ready=1.
- Ignored traffic: u_hat_wr_en with û=1 at address 3 while IDLE and while HOLD. Required: dout unchanged; next frame starts with û cleared.
- Overrun: pulse decoder_busy during EXTRACT. Required: overrun=1 and stays 1; current info_bits correct.
- Reset mid-COLLECT after 3 writes. Required: all outputs at reset values and output_register_ready=1 the same cycle.
- Macro undefined, same stimulus as the nominal case. Required: dout=8'b1100_1000 and dout_valid one cycle after done; info_bits=0.
